// File: rtl/sparse_mult_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sparse_mult_arbiter                                             |
// | Purpose  : Frame-granular two-requester arbiter in front of one shared     |
// |            sparse matrix multiplier. A grant is locked for a whole input   |
// |            frame, the owner is queued in a tag FIFO, and each returned     |
// |            output frame is steered back to the requester that issued it.  |
// | Options  : SPARSE_ARB_RR_EN - round-robin tie-break (default: fixed prio)  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module sparse_mult_arbiter #(
  parameter int unsigned WIDTH     = 96,
  parameter int unsigned IN_LEN    = 11,
  parameter int unsigned OUT_LEN   = 1,
  parameter int unsigned TAG_DEPTH = 4
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_req0_data,
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [WIDTH-1:0] i_req1_data,
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  output logic [WIDTH-1:0] o_resp0_data,
  output logic             o_resp0_valid,
  input  logic             i_resp0_ready,
  output logic [WIDTH-1:0] o_resp1_data,
  output logic             o_resp1_valid,
  input  logic             i_resp1_ready,
  output logic [WIDTH-1:0] o_mult_data,
  output logic             o_mult_valid,
  input  logic             i_mult_ready,
  input  logic [WIDTH-1:0] i_mult_data,
  input  logic             i_mult_valid,
  output logic             o_mult_ready,
  output logic             o_busy,
  output logic             o_err
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam int unsigned PTR_W     = $clog2(TAG_DEPTH) + 1;
  localparam int unsigned IDX_W     = PTR_W - 1;
  localparam int unsigned IN_CNT_W  = (IN_LEN  > 1) ? $clog2(IN_LEN)  : 1;
  localparam int unsigned OUT_CNT_W = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
  localparam logic [IN_CNT_W-1:0]  IN_LAST  = IN_CNT_W'(IN_LEN - 1);
  localparam logic [OUT_CNT_W-1:0] OUT_LAST = OUT_CNT_W'(OUT_LEN - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t               state_q,   state_d;
  logic                 grant_q,   grant_d;
  logic [IN_CNT_W-1:0]  in_cnt_q,  in_cnt_d;
  logic [OUT_CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [PTR_W-1:0]     wr_ptr_q,  wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q,  rd_ptr_d;
  logic                 tag_q [TAG_DEPTH];
  logic                 tag_d [TAG_DEPTH];
  logic                 err_q,     err_d;
`ifdef SPARSE_ARB_RR_EN
  logic                 last_q,    last_d;
`endif

  logic fifo_empty;
  logic fifo_full;
  logic head_tag;
  logic winner;
  logic push;
  logic in_xfer;
  logic out_xfer;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                      (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign head_tag   = tag_q[rd_ptr_q[IDX_W-1:0]];

  // Tie-break between two valid requesters; a lone requester always wins.
`ifdef SPARSE_ARB_RR_EN
  assign winner = (i_req0_valid && i_req1_valid) ? ~last_q : ~i_req0_valid;
`else
  assign winner = ~i_req0_valid;
`endif

  assign push     = (state_q == ST_IDLE) && (i_req0_valid || i_req1_valid) && !fifo_full;
  assign in_xfer  = (state_q == ST_BURST) && o_mult_valid && i_mult_ready;
  assign out_xfer = o_mult_ready && i_mult_valid;

  // Combinational steering of both data paths from the grant and head tag.
  always_comb begin
    o_mult_data   = grant_q ? i_req1_data : i_req0_data;
    o_mult_valid  = 1'b0;
    o_req0_ready  = 1'b0;
    o_req1_ready  = 1'b0;
    if (state_q == ST_BURST) begin
      o_mult_valid = grant_q ? i_req1_valid : i_req0_valid;
      o_req0_ready = ~grant_q & i_mult_ready;
      o_req1_ready =  grant_q & i_mult_ready;
    end
    o_resp0_data  = i_mult_data;
    o_resp1_data  = i_mult_data;
    o_resp0_valid = i_mult_valid & ~fifo_empty & ~head_tag;
    o_resp1_valid = i_mult_valid & ~fifo_empty &  head_tag;
    o_mult_ready  = ~fifo_empty & (head_tag ? i_resp1_ready : i_resp0_ready);
    o_busy        = (state_q == ST_BURST) | ~fifo_empty;
    o_err         = err_q;
  end

  // Next-state: grant/tag push in IDLE, frame counting, tag pop, sticky error.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    tag_d     = tag_q;
    err_d     = err_q | (i_mult_valid & fifo_empty);
`ifdef SPARSE_ARB_RR_EN
    last_d    = last_q;
`endif
    if (push) begin
      state_d                     = ST_BURST;
      grant_d                     = winner;
      tag_d[wr_ptr_q[IDX_W-1:0]]  = winner;
      wr_ptr_d                    = wr_ptr_q + PTR_W'(1);
`ifdef SPARSE_ARB_RR_EN
      last_d                      = winner;
`endif
    end
    if (in_xfer) begin
      if (in_cnt_q == IN_LAST) begin
        in_cnt_d = '0;
        state_d  = ST_IDLE;
      end else begin
        in_cnt_d = in_cnt_q + IN_CNT_W'(1);
      end
    end
    if (out_xfer) begin
      if (out_cnt_q == OUT_LAST) begin
        out_cnt_d = '0;
        rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      end else begin
        out_cnt_d = out_cnt_q + OUT_CNT_W'(1);
      end
    end
  end

  // State registers; reset abandons any partial frame and drops all tags.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      grant_q   <= 1'b0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      tag_q     <= '{default: 1'b0};
      err_q     <= 1'b0;
`ifdef SPARSE_ARB_RR_EN
      last_q    <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      tag_q     <= tag_d;
      err_q     <= err_d;
`ifdef SPARSE_ARB_RR_EN
      last_q    <= last_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sparse_mult_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sparse_mult_arbiter                                          |
// | Purpose  : Directed self-checking bench for sparse_mult_arbiter with a     |
// |            requester/multiplier model and per-port response scoreboard.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_sparse_mult_arbiter;
  localparam int unsigned WIDTH     = 96;
  localparam int unsigned IN_LEN    = 11;
  localparam int unsigned OUT_LEN   = 1;
  localparam int unsigned TAG_DEPTH = 4;

  logic             i_clock = 1'b0;
  logic             i_reset = 1'b1;
  logic [WIDTH-1:0] i_req0_data = '0, i_req1_data = '0, i_mult_data = '0;
  logic             i_req0_valid = 1'b0, i_req1_valid = 1'b0, i_mult_valid = 1'b0;
  logic             i_resp0_ready = 1'b1, i_resp1_ready = 1'b1, i_mult_ready = 1'b1;
  logic [WIDTH-1:0] o_resp0_data, o_resp1_data, o_mult_data;
  logic             o_req0_ready, o_req1_ready, o_resp0_valid, o_resp1_valid;
  logic             o_mult_valid, o_mult_ready, o_busy, o_err;

  logic [WIDTH-1:0] rq0[$], rq1[$], mq[$], exp0[$], exp1[$];
  int               glog[$];
  int               n_assert = 0, n_fail = 0;
  int               cnt0 = 0, cnt1 = 0, acc0 = 0, m_cnt = 0, n_resp0 = 0, n_resp1 = 0;
  logic [WIDTH-1:0] m_acc = '0;
  logic             force_mv = 1'b0;

  sparse_mult_arbiter #(
    .WIDTH(WIDTH), .IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .TAG_DEPTH(TAG_DEPTH)
  ) dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_req0_data(i_req0_data), .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready),
    .i_req1_data(i_req1_data), .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready),
    .o_resp0_data(o_resp0_data), .o_resp0_valid(o_resp0_valid), .i_resp0_ready(i_resp0_ready),
    .o_resp1_data(o_resp1_data), .o_resp1_valid(o_resp1_valid), .i_resp1_ready(i_resp1_ready),
    .o_mult_data(o_mult_data), .o_mult_valid(o_mult_valid), .i_mult_ready(i_mult_ready),
    .i_mult_data(i_mult_data), .i_mult_valid(i_mult_valid), .o_mult_ready(o_mult_ready),
    .o_busy(o_busy), .o_err(o_err)
  );

  always #5 i_clock = ~i_clock;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Requester sources and multiplier model (output = XOR of the frame's words).
  always @(posedge i_clock) begin
    logic t0, t1, tm, tr;
    logic [WIDTH-1:0] dm;
    t0 = i_req0_valid & o_req0_ready;
    t1 = i_req1_valid & o_req1_ready;
    tm = o_mult_valid & i_mult_ready;
    dm = o_mult_data;
    tr = i_mult_valid & o_mult_ready & (mq.size() != 0);
    if (i_reset) begin
      rq0.delete(); rq1.delete(); mq.delete(); exp0.delete(); exp1.delete();
      cnt0 = 0; cnt1 = 0; m_cnt = 0; m_acc = '0;
    end else begin
      if (t0) begin
        if (cnt0 == 0) glog.push_back(0);
        cnt0 = (cnt0 + 1) % IN_LEN;
        acc0++;
        void'(rq0.pop_front());
      end
      if (t1) begin
        if (cnt1 == 0) glog.push_back(1);
        cnt1 = (cnt1 + 1) % IN_LEN;
        void'(rq1.pop_front());
      end
      if (tr) void'(mq.pop_front());
      if (tm) begin
        m_acc = m_acc ^ dm;
        m_cnt++;
        if (m_cnt == IN_LEN) begin
          mq.push_back(m_acc);
          m_acc = '0;
          m_cnt = 0;
        end
      end
    end
    #2;
    i_req0_valid = (rq0.size() != 0);
    i_req0_data  = (rq0.size() != 0) ? rq0[0] : '0;
    i_req1_valid = (rq1.size() != 0);
    i_req1_data  = (rq1.size() != 0) ? rq1[0] : '0;
    i_mult_valid = force_mv || (mq.size() != 0);
    i_mult_data  = (mq.size() != 0) ? mq[0] : '0;
  end

  // Response scoreboard: each accepted product is compared with its port's queue.
  always @(negedge i_clock) begin
    #3;
    if (!i_reset) begin
      if (o_resp0_valid || o_resp1_valid)
        check("resp_one_hot", WIDTH'(o_resp0_valid & o_resp1_valid), '0);
      if (o_resp0_valid && i_resp0_ready) begin
        n_resp0++;
        if (exp0.size() == 0) check("resp0_unexpected", WIDTH'(1), '0);
        else check("resp0_data", o_resp0_data, exp0.pop_front());
      end
      if (o_resp1_valid && i_resp1_ready) begin
        n_resp1++;
        if (exp1.size() == 0) check("resp1_unexpected", WIDTH'(1), '0);
        else check("resp1_data", o_resp1_data, exp1.pop_front());
      end
    end
  end

  task automatic push_frame(input int r, input int f);
    logic [WIDTH-1:0] w, x;
    x = '0;
    for (int k = 0; k < IN_LEN; k++) begin
      w = {32'(r * 1000 + f), 32'(k * 7 + 3), 32'($urandom)};
      x = x ^ w;
      if (r == 0) rq0.push_back(w); else rq1.push_back(w);
    end
    if (r == 0) exp0.push_back(x); else exp1.push_back(x);
  endtask

  task automatic do_reset();
    @(negedge i_clock);
    i_reset = 1'b1;
    repeat (2) @(negedge i_clock);
    i_reset = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge i_clock);
      done = (rq0.size() == 0) && (rq1.size() == 0) && (mq.size() == 0) &&
             (exp0.size() == 0) && (exp1.size() == 0) && !o_busy;
    end
    check(tag, WIDTH'(done), WIDTH'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, WIDTH'({o_req0_ready, o_req1_ready, o_resp0_valid, o_resp1_valid,
                       o_mult_valid, o_mult_ready, o_busy, o_err}), '0);
  endtask

  initial begin
    logic [WIDTH-1:0] w10;
    int exp_order[8];
    int r0;

    // Reset values, then a long quiet stretch.
    repeat (3) @(negedge i_clock);
    check_reset_outputs("reset_outputs");
    i_reset = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge i_clock);
      check("idle_quiet", WIDTH'({o_mult_valid, o_resp0_valid, o_resp1_valid, o_busy, o_err}), '0);
    end

    // Single frame from requester 0 with a known product word.
    w10 = {32'd67108896, 32'd65536, 32'd134217792};
    @(negedge i_clock);
    n_resp0 = 0; n_resp1 = 0;
    for (int k = 0; k < IN_LEN - 1; k++) rq0.push_back('0);
    rq0.push_back(w10);
    exp0.push_back(w10);
    wait_idle("single_frame_done");
    check("single_resp0_count", WIDTH'(n_resp0), WIDTH'(1));
    check("single_resp1_count", WIDTH'(n_resp1), WIDTH'(0));

    // Both requesters continuously valid for four frames each.
    do_reset();
    glog.delete();
    n_resp0 = 0; n_resp1 = 0;
    for (int f = 0; f < 4; f++) begin
      push_frame(0, f);
      push_frame(1, f);
    end
    wait_idle("contend_done");
    for (int i = 0; i < 8; i++) begin
`ifdef SPARSE_ARB_RR_EN
      exp_order[i] = i % 2;
`else
      exp_order[i] = (i < 4) ? 0 : 1;
`endif
    end
    check("contend_grants", WIDTH'(glog.size()), WIDTH'(8));
    for (int i = 0; i < 8 && i < glog.size(); i++)
      check($sformatf("grant_order_%0d", i), WIDTH'(glog[i]), WIDTH'(exp_order[i]));
    check("contend_resp0_count", WIDTH'(n_resp0), WIDTH'(4));
    check("contend_resp1_count", WIDTH'(n_resp1), WIDTH'(4));

    // Tag FIFO full: fifth grant withheld until the first tag pops.
    @(negedge i_clock);
    i_resp0_ready = 1'b0;
    acc0 = 0;
    for (int f = 0; f < 5; f++) push_frame(0, 10 + f);
    repeat (80) @(negedge i_clock);
    check("full_words_accepted", WIDTH'(acc0), WIDTH'(4 * IN_LEN));
    check("full_busy", WIDTH'(o_busy), WIDTH'(1));
    check("full_req0_ready", WIDTH'(o_req0_ready), WIDTH'(0));
    i_resp0_ready = 1'b1;
    @(negedge i_clock);
    check("pop_cycle_req0_ready", WIDTH'(o_req0_ready), WIDTH'(0));
    @(negedge i_clock);
    check("fifth_grant_req0_ready", WIDTH'(o_req0_ready), WIDTH'(1));
    wait_idle("full_done");
    check("full_total_words", WIDTH'(acc0), WIDTH'(5 * IN_LEN));

    // Reset in the middle of a frame, then a clean frame.
    @(negedge i_clock);
    acc0 = 0;
    push_frame(0, 20);
    r0 = 0;
    for (int i = 0; i < 100 && acc0 < 5; i++) @(negedge i_clock);
    check("midframe_words", WIDTH'(acc0), WIDTH'(5));
    i_reset = 1'b1;
    @(negedge i_clock);
    check_reset_outputs("midframe_reset_outputs");
    i_reset = 1'b0;
    n_resp0 = 0;
    push_frame(0, 21);
    wait_idle("post_reset_done");
    check("post_reset_resp0_count", WIDTH'(n_resp0), WIDTH'(1));

    // Multiplier output with no outstanding tag.
    @(negedge i_clock);
    force_mv = 1'b1;
    @(negedge i_clock);
    check("orphan_mult_valid", WIDTH'(i_mult_valid), WIDTH'(1));
    check("orphan_mult_ready", WIDTH'(o_mult_ready), WIDTH'(0));
    @(negedge i_clock);
    check("err_set", WIDTH'(o_err), WIDTH'(1));
    force_mv = 1'b0;
    repeat (6) @(negedge i_clock);
    check("err_sticky", WIDTH'(o_err), WIDTH'(1));
    do_reset();
    @(negedge i_clock);
    check("err_cleared", WIDTH'(o_err), WIDTH'(0));
    r0 = r0 + 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/sparse_mult_arbiter.md
# sparse_mult_arbiter

Frame-granular two-requester arbiter that shares one sparse matrix multiplier instance (any `sparse_mult_by_*` block: WIDTH-bit words, IN_LEN input words per pass, OUT_LEN output words per pass) between two upstream encoder stages. It locks a grant for a whole input frame and records the owner in a tag FIFO. It steers each returned output frame to the requester that issued it. It sits between the LDPC encoder sequencing logic and the shared multiplier.

## Interface
- WIDTH, 96, word width (three 32-bit lanes, passed through untouched)
- IN_LEN, 11, input words per multiplier pass
- OUT_LEN, 1, output words per multiplier pass
- TAG_DEPTH, 4, maximum outstanding frames (power of 2, ≥2)

- i_clock  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_req0_data / i_req1_data  in  WIDTH  requester input words
- i_req0_valid / i_req1_valid  in  1  requester word valid
- o_req0_ready / o_req1_ready  out  1  requester word accepted
- o_resp0_data / o_resp1_data  out  WIDTH  returned product words
- o_resp0_valid / o_resp1_valid  out  1  product valid
- i_resp0_ready / i_resp1_ready  in  1  product accepted
- o_mult_data  out  WIDTH  to multiplier input
- o_mult_valid  out  1  to multiplier input valid
- i_mult_ready  in  1  multiplier input ready
- i_mult_data  in  WIDTH  multiplier output
- i_mult_valid  in  1  multiplier output valid
- o_mult_ready  out  1  multiplier output ready
- o_busy  out  1  grant held or tag FIFO non-empty
- o_err  out  1  sticky: multiplier output arrived with no outstanding tag

## Operation
- Reset is i_reset, synchronous, active-high; clock is i_clock.
- Input FSM states:
  - IDLE: no grant; both o_reqN_ready = 0, o_mult_valid = 0.
  - BURST: grant g ∈ {0,1} held.
- IDLE→BURST when at least one i_reqN_valid = 1 and the tag FIFO is not full:
  - Register g and push tag g in the same cycle.
  - If both requesters are valid, the winner is chosen per Configuration.
- In BURST:
  - o_mult_data = i_req{g}_data and o_mult_valid = i_req{g}_valid.
  - o_req{g}_ready = i_mult_ready; the non-granted requester's ready = 0.
  - in_cnt (0..IN_LEN-1) increments on each transfer (valid & ready).
  - The transfer with in_cnt = IN_LEN-1 clears in_cnt and returns to IDLE.
- Output path:
  - Head tag h selects the destination.
  - o_resp{h}_data = i_mult_data and o_resp{h}_valid = i_mult_valid & ~empty; the other response port's valid = 0.
  - o_mult_ready = i_resp{h}_ready & ~empty.
  - out_cnt (0..OUT_LEN-1) counts transfers; the transfer with out_cnt = OUT_LEN-1 pops the tag and clears out_cnt.
- Tag FIFO pointers are log2(TAG_DEPTH)+1 bits; full/empty are derived from the MSB and the compare.
  - Simultaneous push and pop is legal at any occupancy where the push is permitted, and count is unchanged.
  - Push is never permitted when full, even if a pop occurs in the same cycle.
- i_mult_valid = 1 while the tag FIFO is empty:
  - o_mult_ready stays 0 (the word stalls at the multiplier).
  - o_err sets and holds until reset.
- The requester side does not support a partial frame: once granted, the arbiter waits indefinitely for the remaining words.

## Timing
- Reset values:
  - all o_reqN_ready, o_respN_valid, o_mult_valid, o_mult_ready, o_busy, o_err = 0
  - state IDLE, in_cnt = out_cnt = 0, tag FIFO empty
  - round-robin last-served = 1, so requester 0 wins first
- Grant latency: the grant registers at the clock edge where IDLE sees a valid requester; the first word can transfer the following cycle. This gives one bubble cycle per frame.
- Back-to-back frames: the minimum input occupancy is IN_LEN+1 cycles per frame.
- Data, valid and ready on both the input and output paths are combinational pass-throughs (zero register latency).
- Reset mid-operation: the partial frame is abandoned and tags are discarded. The shared multiplier must be reset by the same i_reset.

## Configuration
- SPARSE_ARB_RR_EN defined: round-robin; when both requesters are valid in IDLE, the one not granted last wins. Last-served updates on every grant.
- SPARSE_ARB_RR_EN undefined: fixed priority; requester 0 always wins ties. The last-served register is not implemented.

## Test plan
- Reset, then 2000 cycles with all valids low -> o_mult_valid, both o_respN_valid, o_busy and o_err stay 0.
- Req0 sends 11 words (multiplier model returns word 10, e.g. low/mid/high = 134217792/65536/67108896), req1 idle -> exactly one word appears on resp0, with that value; resp1 never valid.
- Both requesters continuously valid for 4 frames each, all readies high -> with SPARSE_ARB_RR_EN, grant order 0,1,0,1,…, and each resp port gets 4 words matching its own frames in order. Without the macro, grant order is 0,0,0,0,1,1,1,1.
- i_resp0_ready held low, req0 sends 5 frames -> 4 grants issued (FIFO full) and the 5th grant is withheld. After i_resp0_ready rises and the first tag pops, the 5th grant occurs the next cycle.
- Assert i_reset after 5 of 11 words of a frame -> the next cycle shows all outputs at reset values; a subsequent full frame is returned correctly.
- i_mult_valid = 1 with the tag FIFO empty -> o_mult_ready = 0, o_err = 1, and o_err stays 1 until i_reset.
